// File: rtl/decode_pkg.sv
// Shared decode encodings for decode_stage_hz: opcodes, immediate formats,
// ALU/result-source encodings and the bubble control word.
package decode_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        alu_ctrl_e   alu_control;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_write:   1'b0,
        result_src:  RES_ALU,
        mem_write:   1'b0,
        branch:      1'b0,
        jump:        1'b0,
        alu_src:     1'b0,
        alu_control: ALU_ADD
    };

    // 32-bit sign-extended immediate; the caller widens to XLEN.
    function automatic logic [31:0] imm32(input logic [31:0] instr, input imm_src_e src);
        case (src)
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            default: imm32 = {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Architectural register file: NREGS x XLEN, async active-low clear,
// two combinational read ports, one write port, optional W->D bypass.
module decode_regfile #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int RF_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic            we,
    input  logic [4:0]      rdw,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = we && (rdw != 5'd0) && ({1'b0, rdw} < NREGS_L);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[rdw[AW-1:0]] <= wd;
        end
    end

    // x0 and indices beyond NREGS read as zero before any bypass is considered.
    function automatic logic [XLEN-1:0] read_port(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] stored,
        input logic            w_en,
        input logic [4:0]      w_idx,
        input logic [XLEN-1:0] w_data
    );
        if (rs == 5'd0 || {1'b0, rs} >= NREGS_L)
            read_port = '0;
        else if (RF_BYPASS != 0 && w_en && w_idx == rs)
            read_port = w_data;
        else
            read_port = stored;
    endfunction

    assign rd1 = read_port(rs1, regs[rs1[AW-1:0]], we, rdw, wd);
    assign rd2 = read_port(rs2, regs[rs2[AW-1:0]], we, rdw, wd);

endmodule

// File: rtl/decode_stage_hz.sv
// RISC-V decode stage with register file, ID/EX register and load-use stall.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds the registered IllegalE flag.
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int RF_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic            ALUSrcE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [4:0]      RD_E,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic            IllegalE,
`endif
    output logic            StallF,
    output logic            StallD
);
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm_ext;
    ctrl_t           ctrl_d, ctrl_e;
    imm_src_e        imm_src;
    alu_ctrl_e       alu_fn;
    logic            fn_legal, legal;
    logic            lw_stall, bubble;

    assign opcode = InstrD[6:0];
    assign rd     = InstrD[11:7];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign funct7 = InstrD[31:25];

    decode_regfile #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .RF_BYPASS (RF_BYPASS)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .rs1 (rs1),
        .rs2 (rs2),
        .we  (RegWriteW),
        .rdw (RDW),
        .wd  (ResultW),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    always_comb begin
        alu_fn   = ALU_ADD;
        fn_legal = 1'b1;
        case (funct3)
            3'b000:  alu_fn = (opcode == OP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_fn = ALU_SLT;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            default: fn_legal = 1'b0;
        endcase
        // R-type only accepts funct7 = 0, or 0100000 for sub.
        if (opcode == OP_RTYPE &&
            !(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000)))
            fn_legal = 1'b0;
    end

    always_comb begin
        ctrl_d  = CTRL_NOP;
        imm_src = IMM_I;
        legal   = 1'b1;
        case (opcode)
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = RES_MEM;
            end
            OP_SW: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_src          = IMM_S;
            end
            OP_RTYPE: begin
                legal              = fn_legal;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_control = alu_fn;
            end
            OP_IALU: begin
                legal              = fn_legal;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = alu_fn;
            end
            OP_BEQ: begin
                ctrl_d.branch      = 1'b1;
                ctrl_d.alu_control = ALU_SUB;
                imm_src            = IMM_B;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.result_src = RES_PC4;
                imm_src           = IMM_J;
            end
            OP_LUI: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_src          = IMM_U;
            end
            default: legal = 1'b0;
        endcase
        // Unknown encodings never write state, trap build or not.
        if (!legal) ctrl_d = CTRL_NOP;
    end

    assign imm_ext = XLEN'($signed(imm32(InstrD, imm_src)));

    assign lw_stall = (ctrl_e.result_src == RES_MEM) && (RD_E != 5'd0) &&
                      (RD_E == rs1 || RD_E == rs2);
    assign bubble   = FlushE || lw_stall;
    assign StallF   = lw_stall && !FlushE;
    assign StallD   = lw_stall && !FlushE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_e    <= CTRL_NOP;
            RD1_E     <= '0;
            RD2_E     <= '0;
            Imm_Ext_E <= '0;
            PCE       <= '0;
            PCPlus4E  <= '0;
            RS1_E     <= '0;
            RS2_E     <= '0;
            RD_E      <= '0;
        end else if (bubble) begin
            ctrl_e    <= CTRL_NOP;
            RD1_E     <= '0;
            RD2_E     <= '0;
            Imm_Ext_E <= '0;
            PCE       <= '0;
            PCPlus4E  <= '0;
            RS1_E     <= '0;
            RS2_E     <= '0;
            RD_E      <= '0;
        end else begin
            ctrl_e    <= ctrl_d;
            RD1_E     <= rd1;
            RD2_E     <= rd2;
            Imm_Ext_E <= imm_ext;
            PCE       <= PCD;
            PCPlus4E  <= PCPlus4D;
            RS1_E     <= rs1;
            RS2_E     <= rs2;
            RD_E      <= rd;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        IllegalE <= 1'b0;
        else if (bubble) IllegalE <= 1'b0;
        else             IllegalE <= !legal;
    end
`endif

    assign RegWriteE   = ctrl_e.reg_write;
    assign ResultSrcE  = ctrl_e.result_src;
    assign MemWriteE   = ctrl_e.mem_write;
    assign BranchE     = ctrl_e.branch;
    assign JumpE       = ctrl_e.jump;
    assign ALUSrcE     = ctrl_e.alu_src;
    assign ALUControlE = ctrl_e.alu_control;

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised successor to the fixed 32-bit decode cycle, sitting between the IF/ID and EX stages of the 5-stage RISC-V pipeline.
- Holds the architectural register file with W-stage write-through bypass and decodes control signals and immediates.
- Registers all decode results into the ID/EX pipeline register, with stall and flush control.
- Detects load-use hazards internally and drives the stall/bubble signals for the upstream stages.

Parameters:
- XLEN, 32, datapath width; immediates sign-extend to XLEN.
- NREGS, 32, architectural register count (32 = RV32I, 16 = RV32E).
- RF_BYPASS, 1, 1 = same-cycle W write visible to D read; 0 = read returns the old value.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- InstrD  in  32  instruction in decode.
- PCD  in  XLEN  PC of InstrD.
- PCPlus4D  in  XLEN  PCD+4.
- FlushE  in  1  branch/jump taken in EX; load a bubble into ID/EX.
- RegWriteW  in  1  writeback enable.
- RDW  in  5  writeback destination.
- ResultW  in  XLEN  writeback data.
- RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  out  1 each  registered control.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN each  registered data.
- RS1_E, RS2_E, RD_E  out  5 each  registered register indices.
- StallF, StallD  out  1 each  combinational load-use stall.

Behaviour:
- Reset (rst=0, asynchronous): every E output is 0, every register-file entry is 0, and the stage emits a NOP bubble.
- Latency: InstrD to E outputs is 1 clock.
- Register file write: on a rising edge, write when RegWriteW=1, RDW!=0 and RDW<NREGS.
  - Writes to x0 or to out-of-range indices are ignored.
- Register file read: combinational.
  - x0 and out-of-range indices read 0.
  - With RF_BYPASS=1, a read with RS==RDW, RegWriteW=1 and RDW!=0 returns ResultW.
- Main decoder opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
  - lui 0110111
  - Any other opcode decodes to all-zero control (NOP).
- Immediate types: I, S, B, J, U; B and J have LSB 0; U is {imm[31:12], 12'b0}. All sign-extend to XLEN.
- ALU decode:
  - funct3 000 with funct7[5] and R-type gives sub, otherwise add.
  - funct3 010 gives slt, 110 gives or, 111 gives and.
  - lw/sw/jal/lui use add.
  - beq uses sub.
- Load-use hazard: lwStall = (ResultSrcE==01) & (RD_E!=0) & (RD_E==InstrD[19:15] | RD_E==InstrD[24:20]).
  - StallF = StallD = lwStall & ~FlushE.
- ID/EX register update, evaluated in this order:
  1. FlushE=1 or lwStall=1: load a bubble (all control 0, data/index fields 0).
  2. Otherwise: load the decoded values.
  - FlushE and lwStall together: bubble loaded and StallF/StallD=0, since the D instruction is squashed upstream.
- Reset deasserting mid-operation: the first edge after deassertion loads the current D decode normally.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Extra output IllegalE (1 bit, reset 0, registered with ID/EX, cleared by bubble).
  - IllegalE is set for an unrecognised opcode, or for funct3/funct7 combinations not listed above.
  - Illegal instructions additionally force RegWriteE=MemWriteE=BranchE=JumpE=0.
- Undefined: no IllegalE port, and unknown encodings silently become NOPs.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams
  - ImmSrc encodings (I, S, B, J, U)
  - ALUControl and ResultSrc encodings
  - NOP/bubble control constant
- One sub-module, decode_regfile: NREGS x XLEN registers with async active-low clear, two read ports and one write port, plus the RF_BYPASS logic.
- Control decoder, immediate extender, hazard logic and ID/EX register stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> all E outputs 0 and StallF/StallD=0; after release, InstrD=32'h00000013 (addi x0,x0,0) -> RegWriteE=1, RD_E=0, Imm_Ext_E=0.
- Bypass: RegWriteW=1, RDW=5, ResultW=32'hDEADBEEF, InstrD=32'h00528333 (add x6,x5,x5) in the same cycle -> next cycle RD1_E=RD2_E=32'hDEADBEEF, ALUControlE=000; with RF_BYPASS=0 -> 0.
- Immediates:
  - InstrD=32'hFFC4A303 (lw x6,-4(x9)) -> Imm_Ext_E=32'hFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
  - InstrD=32'h008000EF (jal x1,8) -> Imm_Ext_E=8, JumpE=1, ResultSrcE=10.
- Load-use:
  - Cycle n: lw x6,0(x9).
  - Cycle n+1: InstrD=32'h00630333 (add x6,x6,x6) -> StallF=StallD=1 and bubble in E at n+2.
  - Next cycle the add enters E.
- Flush priority: same setup as the load-use case with FlushE=1 -> StallF=StallD=0 and bubble in E.
- x0 write: RegWriteW=1, RDW=0, ResultW=32'h12345678, then read x0 -> RD1_E=0.
